int_entry_ctrl: RTL and testbench
=================================

# int_entry_ctrl

Exception-entry sequencer for IRQ/FIQ, directly downstream of the interrupt request latch. At an instruction boundary it samples the latched `INT_fiq`/`INT_irq` lines and runs a fixed multi-cycle entry sequence:

- acknowledge the request;
- bank CPSR into the target mode's SPSR and write the return address to LR;
- switch mode and mask bits;
- redirect PC to the vector.

While the sequence runs it stalls the fetch/execute path through `Busy`.

## Interface
Parameters:
- VEC_IRQ, 32'h0000_0018, IRQ vector address
- VEC_FIQ, 32'h0000_001C, FIQ vector address

Ports:
- clk  input  1  single clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- INT_fiq  input  1  latched FIQ request (level)
- INT_irq  input  1  latched IRQ request (level, already suppressed by request logic when INT_fiq=1)
- Instr_done  input  1  one-cycle pulse: current instruction retired, boundary reached
- PC_next  input  32  address of next unexecuted instruction
- CPSR  input  32  current CPSR
- INTA_fiq  output  1  one-cycle FIQ acknowledge (clears request latch)
- INTA_irq  output  1  one-cycle IRQ acknowledge
- Busy  output  1  high in every non-IDLE state; stalls fetch and execute
- Int_mode  output  5  target mode for banked SPSR/LR write: 5'b10001 FIQ, 5'b10010 IRQ
- SPSR_write  output  1  write SPSR_data to SPSR bank selected by Int_mode
- SPSR_data  output  32  captured CPSR
- LR_write  output  1  write LR_data to LR bank selected by Int_mode
- LR_data  output  32  captured PC_next + 4
- CPSR_write  output  1  write CPSR_data to CPSR
- CPSR_data  output  32  new CPSR
- PC_write  output  1  load PC_data into PC
- PC_data  output  32  vector address

## Operation
- FSM states: IDLE, ACK, SAVE, JUMP. Encoding is free.
- All outputs are decoded from state and captured registers (Moore). Nothing is combinational from inputs.

IDLE → ACK: on Instr_done=1 and a take condition:
- Take FIQ if INT_fiq=1 and CPSR[6]=0.
- Otherwise take IRQ if INT_irq=1 and CPSR[7]=0.
- FIQ has strict priority.
- On the transition, capture: type bit (fiq/irq), CPSR → cap_cpsr, PC_next → cap_pc.

Each following state lasts one cycle:
- ACK: pulse INTA_fiq or INTA_irq, matching the captured type. Then go to SAVE.
- SAVE: assert SPSR_write, LR_write and CPSR_write together.
  - SPSR_data = cap_cpsr.
  - LR_data = cap_pc + 4, modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - CPSR_data = cap_cpsr with [4:0]=Int_mode, [5]=0, [7]=1, and [6]=1 for FIQ only (IRQ leaves F unchanged). All other bits are preserved.
  - Then go to JUMP.
- JUMP: assert PC_write, with PC_data = VEC_FIQ or VEC_IRQ. Then go to IDLE.

Other rules:
- Int_mode is valid from ACK through JUMP. It is 0 in IDLE.
- Data outputs are 0 whenever their write strobe is low.
- Instr_done is ignored outside IDLE. Requests that change mid-sequence are ignored.
- A request that is masked or absent at the boundary is not taken. It is re-evaluated at the next Instr_done.
- FIQ pending during an IRQ entry is taken at the first boundary after the sequence. IRQ entry does not set F, so FIQ can preempt.

## Timing
- Reset (async): state=IDLE, capture registers=0. Every output is 0: Busy, INTA_*, all write strobes, all data outputs, Int_mode.
- Reset asserted mid-sequence aborts the sequence immediately. No further strobes are issued, and no partial state is retained after reset deasserts.
- Cycle numbering, with the Instr_done edge as 0:
  - Cycle 1 (ACK): Busy=1, INTA pulse.
  - Cycle 2 (SAVE): SPSR/LR/CPSR writes.
  - Cycle 3 (JUMP): PC_write.
  - Cycle 4: IDLE, Busy=0.
- Entry latency is 3 cycles to PC_write. Busy is high for exactly 3 cycles.
- Back-to-back: an Instr_done in the cycle after JUMP, with a pending request, starts a new sequence.

## Test plan
- Reset, then CPSR=32'h0000_0013, INT_irq=1, Instr_done pulse, PC_next=32'h100. Required:
  - INTA_irq high only in cycle 1.
  - Cycle 2: SPSR_data=32'h13, LR_data=32'h104, CPSR_data=32'h92, Int_mode=5'h12.
  - Cycle 3: PC_data=32'h18.
  - Busy=1 for cycles 1-3.
- INT_fiq=1 and INT_irq=1 together, CPSR=32'h13. Required: FIQ taken, INTA_irq never asserted, CPSR_data=32'hD1, PC_data=32'h1C.
- INT_irq=1 with CPSR[7]=1, Instr_done pulse. Required: stays IDLE, no strobes. Clear CPSR[7], pulse Instr_done again → IRQ entry runs.
- INT_fiq rises during the SAVE state of an IRQ entry. Required: IRQ sequence completes unchanged, then the FIQ sequence starts on the next Instr_done.
- Rst asserted in SAVE. Required: all outputs 0 in the same cycle. After release, with no Instr_done, no PC_write ever occurs.
- PC_next=32'hFFFF_FFFC with an IRQ entry. Required: LR_data=32'h0000_0000.

Source files
------------

// File: rtl/int_entry_ctrl.sv
// IRQ/FIQ exception-entry sequencer: samples latched requests at an instruction
// boundary and issues acknowledge, SPSR/LR/CPSR banking and the vector jump.
module int_entry_ctrl #(
    parameter logic [31:0] VEC_IRQ = 32'h0000_0018,
    parameter logic [31:0] VEC_FIQ = 32'h0000_001C
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        INT_fiq,
    input  logic        INT_irq,
    input  logic        Instr_done,
    input  logic [31:0] PC_next,
    input  logic [31:0] CPSR,
    output logic        INTA_fiq,
    output logic        INTA_irq,
    output logic        Busy,
    output logic [4:0]  Int_mode,
    output logic        SPSR_write,
    output logic [31:0] SPSR_data,
    output logic        LR_write,
    output logic [31:0] LR_data,
    output logic        CPSR_write,
    output logic [31:0] CPSR_data,
    output logic        PC_write,
    output logic [31:0] PC_data,
    output logic [1:0]  dbg_state
);

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_SAVE = 2'd2,
        S_JUMP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_fiq_q, is_fiq_d;
    logic [31:0] cap_cpsr_q, cap_cpsr_d;
    logic [31:0] cap_pc_q, cap_pc_d;

    logic        take_fiq;
    logic        take_irq;
    logic [4:0]  mode;
    logic [31:0] new_cpsr;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            is_fiq_q   <= 1'b0;
            cap_cpsr_q <= 32'd0;
            cap_pc_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_fiq_q   <= is_fiq_d;
            cap_cpsr_q <= cap_cpsr_d;
            cap_pc_q   <= cap_pc_d;
        end
    end

    // Handshake: Instr_done is a one-cycle strobe honoured only in IDLE; the
    // matching INTA_* is a one-cycle acknowledge issued the following cycle.
    // There is no back-pressure in either direction.
    always_comb begin
        state_d    = state_q;
        is_fiq_d   = is_fiq_q;
        cap_cpsr_d = cap_cpsr_q;
        cap_pc_d   = cap_pc_q;
        take_fiq   = INT_fiq && !CPSR[6];
        take_irq   = INT_irq && !CPSR[7];
        case (state_q)
            S_IDLE: begin
                if (Instr_done && (take_fiq || take_irq)) begin
                    state_d    = S_ACK;
                    is_fiq_d   = take_fiq;
                    cap_cpsr_d = CPSR;
                    cap_pc_d   = PC_next;
                end
            end
            S_ACK:   state_d = S_SAVE;
            S_SAVE:  state_d = S_JUMP;
            S_JUMP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode: only state and captured registers feed the outputs.
    always_comb begin
        mode         = is_fiq_q ? MODE_FIQ : MODE_IRQ;
        new_cpsr     = cap_cpsr_q;
        new_cpsr[4:0] = mode;
        new_cpsr[5]  = 1'b0;
        new_cpsr[7]  = 1'b1;
        if (is_fiq_q) begin
            new_cpsr[6] = 1'b1;
        end

        Busy       = 1'b0;
        INTA_fiq   = 1'b0;
        INTA_irq   = 1'b0;
        Int_mode   = 5'd0;
        SPSR_write = 1'b0;
        SPSR_data  = 32'd0;
        LR_write   = 1'b0;
        LR_data    = 32'd0;
        CPSR_write = 1'b0;
        CPSR_data  = 32'd0;
        PC_write   = 1'b0;
        PC_data    = 32'd0;

        case (state_q)
            S_ACK: begin
                Busy     = 1'b1;
                Int_mode = mode;
                INTA_fiq = is_fiq_q;
                INTA_irq = !is_fiq_q;
            end
            S_SAVE: begin
                Busy       = 1'b1;
                Int_mode   = mode;
                SPSR_write = 1'b1;
                SPSR_data  = cap_cpsr_q;
                LR_write   = 1'b1;
                LR_data    = cap_pc_q + 32'd4;
                CPSR_write = 1'b1;
                CPSR_data  = new_cpsr;
            end
            S_JUMP: begin
                Busy     = 1'b1;
                Int_mode = mode;
                PC_write = 1'b1;
                PC_data  = is_fiq_q ? VEC_FIQ : VEC_IRQ;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_int_entry_ctrl.sv
// Directed bench for int_entry_ctrl: table of entry vectors plus hand-written
// sequences for mid-sequence request changes and reset abort.
module tb_int_entry_ctrl;

    logic        clk;
    logic        Rst;
    logic        INT_fiq;
    logic        INT_irq;
    logic        Instr_done;
    logic [31:0] PC_next;
    logic [31:0] CPSR;
    logic        INTA_fiq;
    logic        INTA_irq;
    logic        Busy;
    logic [4:0]  Int_mode;
    logic        SPSR_write;
    logic [31:0] SPSR_data;
    logic        LR_write;
    logic [31:0] LR_data;
    logic        CPSR_write;
    logic [31:0] CPSR_data;
    logic        PC_write;
    logic [31:0] PC_data;
    logic [1:0]  dbg_state;

    int errors;
    int checks;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        fiq;
        logic        irq;
        logic [31:0] cpsr;
        logic [31:0] pc;
        logic        take;
        logic        is_fiq;
        logic [31:0] lr;
        logic [31:0] cpsr_new;
        logic [31:0] vec;
    } vec_t;

    vec_t vecs[10];

    int_entry_ctrl dut (
        .clk        (clk),
        .Rst        (Rst),
        .INT_fiq    (INT_fiq),
        .INT_irq    (INT_irq),
        .Instr_done (Instr_done),
        .PC_next    (PC_next),
        .CPSR       (CPSR),
        .INTA_fiq   (INTA_fiq),
        .INTA_irq   (INTA_irq),
        .Busy       (Busy),
        .Int_mode   (Int_mode),
        .SPSR_write (SPSR_write),
        .SPSR_data  (SPSR_data),
        .LR_write   (LR_write),
        .LR_data    (LR_data),
        .CPSR_write (CPSR_write),
        .CPSR_data  (CPSR_data),
        .PC_write   (PC_write),
        .PC_data    (PC_data),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    function automatic vec_t mk(input logic fiq, input logic irq, input logic [31:0] cpsr,
                                input logic [31:0] pc, input logic take, input logic is_fiq,
                                input logic [31:0] lr, input logic [31:0] cpsr_new,
                                input logic [31:0] vec);
        vec_t v;
        v.fiq = fiq; v.irq = irq; v.cpsr = cpsr; v.pc = pc; v.take = take;
        v.is_fiq = is_fiq; v.lr = lr; v.cpsr_new = cpsr_new; v.vec = vec;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        logic [139:0] all_out;
        all_out = {Busy, INTA_fiq, INTA_irq, Int_mode, SPSR_write, SPSR_data, LR_write,
                   LR_data, CPSR_write, CPSR_data, PC_write, PC_data};
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL %s: outputs %h expected all zero at %0t", name, all_out, $time);
        end
    endtask

    // driver: called at a negedge; Instr_done is sampled at the next posedge
    task automatic start_entry(input vec_t v, input bit push_exp);
        INT_fiq    = v.fiq;
        INT_irq    = v.irq;
        CPSR       = v.cpsr;
        PC_next    = v.pc;
        Instr_done = 1'b1;
        if (v.take && push_exp) exp_q.push_back(v.vec);
        @(posedge clk);
        #1;
        Instr_done = 1'b0;
    endtask

    task automatic check_entry(input vec_t v, input bit disturb);
        logic [4:0] m;
        m = v.is_fiq ? 5'h11 : 5'h12;
        if (!v.take) begin
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                chk_zero($sformatf("no_take_c%0d", c));
            end
        end else begin
            @(negedge clk);
            chk1("c1_busy", Busy, 1'b1);
            chk1("c1_inta_fiq", INTA_fiq, v.is_fiq);
            chk1("c1_inta_irq", INTA_irq, !v.is_fiq);
            chk32("c1_mode", {27'd0, Int_mode}, {27'd0, m});
            chk1("c1_spsr_wr", SPSR_write, 1'b0);
            @(negedge clk);
            chk1("c2_busy", Busy, 1'b1);
            chk1("c2_inta_any", INTA_fiq | INTA_irq, 1'b0);
            chk1("c2_spsr_wr", SPSR_write, 1'b1);
            chk1("c2_lr_wr", LR_write, 1'b1);
            chk1("c2_cpsr_wr", CPSR_write, 1'b1);
            chk32("c2_spsr_data", SPSR_data, v.cpsr);
            chk32("c2_lr_data", LR_data, v.lr);
            chk32("c2_cpsr_data", CPSR_data, v.cpsr_new);
            chk32("c2_mode", {27'd0, Int_mode}, {27'd0, m});
            chk1("c2_pc_wr", PC_write, 1'b0);
            if (disturb) begin
                INT_fiq    = 1'b1;
                INT_irq    = 1'b0;
                Instr_done = 1'b1;
            end
            @(negedge clk);
            if (disturb) Instr_done = 1'b0;
            chk1("c3_busy", Busy, 1'b1);
            chk1("c3_pc_wr", PC_write, 1'b1);
            chk32("c3_pc_data", PC_data, v.vec);
            chk1("c3_inta_fiq", INTA_fiq, 1'b0);
            chk1("c3_spsr_wr", SPSR_write | LR_write | CPSR_write, 1'b0);
            chk32("c3_lr_data", LR_data, 32'd0);
            chk32("c3_mode", {27'd0, Int_mode}, {27'd0, m});
            @(negedge clk);
            chk_zero("c4_idle");
        end
    endtask

    // scoreboard: every PC_write must match the next queued vector address
    always @(negedge clk) begin
        if (PC_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pc_write_unexpected: PC_data %h with empty queue at %0t", PC_data, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (PC_data !== e) begin
                    errors++;
                    $display("FAIL pc_write_sb: got %h expected %h at %0t", PC_data, e, $time);
                end
            end
        end
    end

    initial begin
        vec_t vb, vf, vr, vz;
        errors = 0;
        checks = 0;
        //                fiq   irq   cpsr           pc             take  fiq   lr             cpsr_new       vec
        vecs[0] = mk(1'b0, 1'b1, 32'h0000_0013, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0092, 32'h18);
        vecs[1] = mk(1'b1, 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_00D1, 32'h1C);
        vecs[2] = mk(1'b0, 1'b1, 32'h0000_0093, 32'h0000_0300, 1'b0, 1'b0, 32'h0,          32'h0,          32'h0);
        vecs[3] = mk(1'b0, 1'b1, 32'h0000_0013, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0304, 32'h0000_0092, 32'h18);
        vecs[4] = mk(1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0092, 32'h18);
        vecs[5] = mk(1'b1, 1'b0, 32'h0000_0053, 32'h0000_0400, 1'b0, 1'b0, 32'h0,          32'h0,          32'h0);
        vecs[6] = mk(1'b1, 1'b1, 32'h0000_0053, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_00D2, 32'h18);
        vecs[7] = mk(1'b1, 1'b0, 32'hF000_0030, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1004, 32'hF000_00D1, 32'h1C);
        vecs[8] = mk(1'b0, 1'b1, 32'h2000_003F, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_000C, 32'h2000_0092, 32'h18);
        vecs[9] = mk(1'b0, 1'b0, 32'h0000_0013, 32'h0000_0500, 1'b0, 1'b0, 32'h0,          32'h0,          32'h0);

        // reset
        Rst        = 1'b1;
        INT_fiq    = 1'b0;
        INT_irq    = 1'b0;
        Instr_done = 1'b0;
        PC_next    = 32'd0;
        CPSR       = 32'd0;
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs");
        Rst = 1'b0;
        @(negedge clk);
        chk_zero("post_reset_idle");

        // table: each entry starts in the cycle right after the previous JUMP
        for (int i = 0; i < 10; i++) begin
            start_entry(vecs[i], 1'b1);
            check_entry(vecs[i], 1'b0);
        end

        // FIQ rises during SAVE of an IRQ entry; a stray Instr_done is ignored
        vb = mk(1'b0, 1'b1, 32'h0000_0013, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0504, 32'h0000_0092, 32'h18);
        vf = mk(1'b1, 1'b0, 32'h0000_0013, 32'h0000_0600, 1'b1, 1'b1, 32'h0000_0604, 32'h0000_00D1, 32'h1C);
        start_entry(vb, 1'b1);
        check_entry(vb, 1'b1);
        start_entry(vf, 1'b1);
        check_entry(vf, 1'b0);

        // reset asserted in SAVE aborts the sequence
        vr = mk(1'b0, 1'b1, 32'h0000_0013, 32'h0000_0700, 1'b1, 1'b0, 32'h0000_0704, 32'h0000_0092, 32'h18);
        start_entry(vr, 1'b0);
        @(negedge clk);
        chk1("rst_c1_inta_irq", INTA_irq, 1'b1);
        @(negedge clk);
        chk1("rst_c2_in_save", SPSR_write, 1'b1);
        Rst = 1'b1;
        #1;
        chk_zero("reset_in_save");
        @(negedge clk);
        Rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_zero("after_abort_idle");

        // normal entry after the abort
        vz = mk(1'b0, 1'b1, 32'h0000_0013, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0804, 32'h0000_0092, 32'h18);
        start_entry(vz, 1'b1);
        check_entry(vz, 1'b0);

        repeat (2) @(negedge clk);
        chk32("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
